// File: rtl/sweep_controller.sv
// Sweep controller: steps the live output frequency once per millisecond tick
// through sawtooth-up, sawtooth-down or triangle sweeps between a latched low
// bound (base frequency) and high bound (base + range, clamped to FREQ_MAX).
// In mode 00 the output simply follows the base frequency.
module sweep_controller #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FREQ_MAX = 999_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sweep_mode,
    input  logic [19:0] base_freq,
    input  logic [16:0] sweep_range,
    input  logic [12:0] sweep_speed,
    input  logic        hold,
    input  logic        restart,
    output logic [19:0] freq_cur,
    output logic        freq_upd,
    output logic        sweeping,
    output logic        dir_down,
    output logic        wrap
);

    localparam int          TICK_DIV  = CLK_HZ / 1000;
    localparam int          CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [20:0] FMAX_W    = 21'(FREQ_MAX);

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INIT     = 2'd1,
        RUN_UP   = 2'd2,
        RUN_DOWN = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [19:0]      lo_q;
    logic [19:0]      hi_q;
    logic [12:0]      spd_q;
    logic [1:0]       mode_q;
    logic [19:0]      freq_q;
    logic             freq_upd_q;
    logic             sweeping_q;
    logic             dir_down_q;
    logic             wrap_q;

    logic [20:0] hi_sum_d;
    logic [19:0] hi_d;
    logic [20:0] up_sum_d;
    logic [20:0] dn_floor_d;
    logic        tick_d;
    logic        step_ok_d;
    logic        mode_chg_d;

    // Next-bound and step arithmetic, all one bit wider so nothing wraps.
    always_comb begin
        hi_sum_d   = {1'b0, base_freq} + 21'(sweep_range);
        hi_d       = (hi_sum_d > FMAX_W) ? FMAX_W[19:0] : hi_sum_d[19:0];
        up_sum_d   = {1'b0, freq_q} + 21'(spd_q);
        dn_floor_d = {1'b0, lo_q} + 21'(spd_q);
        tick_d     = (cnt_q == TICK_LAST) && !hold;
        // A zero step or a zero-width window leaves the output parked at lo.
        step_ok_d  = (spd_q != 13'd0) && (hi_q != lo_q);
        mode_chg_d = (sweep_mode != mode_q);
    end

    // Sweep FSM with tick counter, latched bounds and registered outputs.
    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values of each other; a blocking '=' would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            spd_q      <= '0;
            mode_q     <= MODE_OFF;
            freq_q     <= '0;
            freq_upd_q <= 1'b0;
            sweeping_q <= 1'b0;
            dir_down_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            freq_upd_q <= 1'b0;
            wrap_q     <= 1'b0;
            if (sweep_mode == MODE_OFF && state_q != IDLE) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                sweeping_q <= 1'b0;
                dir_down_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sweep_mode != MODE_OFF) begin
                            state_q <= INIT;
                        end else begin
                            freq_q     <= base_freq;
                            freq_upd_q <= (base_freq != freq_q);
                        end
                    end
                    INIT: begin
                        lo_q       <= base_freq;
                        hi_q       <= hi_d;
                        spd_q      <= sweep_speed;
                        mode_q     <= sweep_mode;
                        cnt_q      <= '0;
                        sweeping_q <= 1'b1;
                        if (sweep_mode == MODE_DOWN) begin
                            state_q    <= RUN_DOWN;
                            dir_down_q <= 1'b1;
                            freq_q     <= hi_d;
                            freq_upd_q <= (hi_d != freq_q);
                        end else begin
                            state_q    <= RUN_UP;
                            dir_down_q <= 1'b0;
                            freq_q     <= base_freq;
                            freq_upd_q <= (base_freq != freq_q);
                        end
                    end
                    RUN_UP: begin
                        if (restart || mode_chg_d) begin
                            state_q    <= INIT;
                            sweeping_q <= 1'b0;
                        end else if (!hold) begin
                            cnt_q <= (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
                            if (tick_d && step_ok_d) begin
                                if (up_sum_d <= {1'b0, hi_q}) begin
                                    freq_q     <= up_sum_d[19:0];
                                    freq_upd_q <= 1'b1;
                                end else if (mode_q == MODE_UP) begin
                                    // Sawtooth wrap: restart at lo with fresh config.
                                    lo_q       <= base_freq;
                                    hi_q       <= hi_d;
                                    spd_q      <= sweep_speed;
                                    freq_q     <= base_freq;
                                    freq_upd_q <= (base_freq != freq_q);
                                    wrap_q     <= 1'b1;
                                end else begin
                                    // Triangle turnaround at the top; no wrap pulse here.
                                    state_q    <= RUN_DOWN;
                                    dir_down_q <= 1'b1;
                                    freq_q     <= hi_q;
                                    freq_upd_q <= (hi_q != freq_q);
                                end
                            end
                        end
                    end
                    RUN_DOWN: begin
                        if (restart || mode_chg_d) begin
                            state_q    <= INIT;
                            sweeping_q <= 1'b0;
                        end else if (!hold) begin
                            cnt_q <= (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
                            if (tick_d && step_ok_d) begin
                                lo_q  <= lo_q;
                                if ({1'b0, freq_q} >= dn_floor_d) begin
                                    freq_q     <= freq_q - 20'(spd_q);
                                    freq_upd_q <= 1'b1;
                                end else if (mode_q == MODE_DOWN) begin
                                    // Sawtooth wrap: jump back to the fresh hi.
                                    lo_q       <= base_freq;
                                    hi_q       <= hi_d;
                                    spd_q      <= sweep_speed;
                                    freq_q     <= hi_d;
                                    freq_upd_q <= (hi_d != freq_q);
                                    wrap_q     <= 1'b1;
                                end else begin
                                    // Triangle turnaround at the bottom.
                                    state_q    <= RUN_UP;
                                    dir_down_q <= 1'b0;
                                    lo_q       <= base_freq;
                                    hi_q       <= hi_d;
                                    spd_q      <= sweep_speed;
                                    freq_q     <= base_freq;
                                    freq_upd_q <= (base_freq != freq_q);
                                    wrap_q     <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign freq_cur = freq_q;
    assign freq_upd = freq_upd_q;
    assign sweeping = sweeping_q;
    assign dir_down = dir_down_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller at CLK_HZ=10_000 (10-cycle ms tick).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sweep_controller;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sweep_mode;
    logic [19:0] base_freq;
    logic [16:0] sweep_range;
    logic [12:0] sweep_speed;
    logic        hold;
    logic        restart;
    logic [19:0] freq_cur;
    logic        freq_upd;
    logic        sweeping;
    logic        dir_down;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int n;
    int wraps;
    int upds;

    sweep_controller #(
        .CLK_HZ  (10_000),
        .FREQ_MAX(999_999)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sweep_mode (sweep_mode),
        .base_freq  (base_freq),
        .sweep_range(sweep_range),
        .sweep_speed(sweep_speed),
        .hold       (hold),
        .restart    (restart),
        .freq_cur   (freq_cur),
        .freq_upd   (freq_upd),
        .sweeping   (sweeping),
        .dir_down   (dir_down),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    // Advance until freq_upd is seen; cycles taken returned in cyc (200 = timeout).
    task automatic wait_upd(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!freq_upd && cyc < 200);
    endtask

    initial begin
        rst_n       = 1'b0;
        sweep_mode  = 2'b00;
        base_freq   = 20'd0;
        sweep_range = 17'd0;
        sweep_speed = 13'd0;
        hold        = 1'b0;
        restart     = 1'b0;
        step(2);
        check("rst_freq", 32'(freq_cur), 0);
        check("rst_upd", 32'(freq_upd), 0);
        check("rst_sweeping", 32'(sweeping), 0);
        check("rst_dir", 32'(dir_down), 0);
        check("rst_wrap", 32'(wrap), 0);
        rst_n = 1'b1;
        step(1);

        // Static mode: output follows base one cycle later with a single pulse.
        base_freq = 20'd1000;
        step(1);
        check("idle_freq", 32'(freq_cur), 1000);
        check("idle_upd", 32'(freq_upd), 1);
        check("idle_sweeping", 32'(sweeping), 0);
        step(1);
        check("idle_upd_once", 32'(freq_upd), 0);

        // Sawtooth up 1000..4000, wrap back to 1000.
        sweep_range = 17'd3000;
        sweep_speed = 13'd1000;
        sweep_mode  = 2'b01;
        step(2);
        check("saw_start", 32'(freq_cur), 1000);
        check("saw_sweeping", 32'(sweeping), 1);
        check("saw_dir", 32'(dir_down), 0);
        wait_upd(n); check("saw_gap1", 32'(n), 10); check("saw_f1", 32'(freq_cur), 2000);
        check("saw_nowrap", 32'(wrap), 0);
        wait_upd(n); check("saw_gap2", 32'(n), 10); check("saw_f2", 32'(freq_cur), 3000);
        wait_upd(n); check("saw_gap3", 32'(n), 10); check("saw_f3", 32'(freq_cur), 4000);
        wait_upd(n); check("saw_gap4", 32'(n), 10); check("saw_f4", 32'(freq_cur), 1000);
        check("saw_wrap", 32'(wrap), 1);

        // Hold for 25 cycles five cycles into the tick period.
        step(5);
        hold = 1'b1;
        step(25);
        check("hold_freq", 32'(freq_cur), 1000);
        hold = 1'b0;
        wait_upd(n); check("hold_resume_gap", 32'(n), 5); check("hold_f", 32'(freq_cur), 2000);

        // Restart in the very cycle a tick is due: INIT wins, no step to 3000.
        step(9);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart_nostep", 32'(freq_cur), 2000);
        step(1);
        check("restart_lo", 32'(freq_cur), 1000);
        check("restart_upd", 32'(freq_upd), 1);

        // Triangle: 1000..4000, turn (silent), 3000,2000,1000, turn+wrap, 2000.
        sweep_mode = 2'b11;
        step(2);
        check("tri_start", 32'(freq_cur), 1000);
        wait_upd(n); check("tri_gap1", 32'(n), 10); check("tri_f1", 32'(freq_cur), 2000);
        wait_upd(n); check("tri_f2", 32'(freq_cur), 3000);
        wait_upd(n); check("tri_f3", 32'(freq_cur), 4000);
        check("tri_dir_up", 32'(dir_down), 0);
        wait_upd(n); check("tri_gap_turn", 32'(n), 20); check("tri_f4", 32'(freq_cur), 3000);
        check("tri_dir_down", 32'(dir_down), 1);
        wait_upd(n); check("tri_f5", 32'(freq_cur), 2000);
        wait_upd(n); check("tri_f6", 32'(freq_cur), 1000);
        check("tri_f6_nowrap", 32'(wrap), 0);
        step(10);
        check("tri_bottom_wrap", 32'(wrap), 1);
        check("tri_bottom_dir", 32'(dir_down), 0);
        check("tri_bottom_freq", 32'(freq_cur), 1000);
        wait_upd(n); check("tri_gap_up", 32'(n), 10); check("tri_f7", 32'(freq_cur), 2000);

        // Sawtooth down near the top: hi clamps to FREQ_MAX.
        base_freq   = 20'd999000;
        sweep_range = 17'd5000;
        sweep_speed = 13'd300;
        sweep_mode  = 2'b10;
        step(2);
        check("down_start", 32'(freq_cur), 999999);
        check("down_dir", 32'(dir_down), 1);
        wait_upd(n); check("down_gap1", 32'(n), 10); check("down_f1", 32'(freq_cur), 999699);
        wait_upd(n); check("down_f2", 32'(freq_cur), 999399);
        wait_upd(n); check("down_f3", 32'(freq_cur), 999099);
        check("down_f3_nowrap", 32'(wrap), 0);
        wait_upd(n); check("down_gap4", 32'(n), 10); check("down_f4", 32'(freq_cur), 999999);
        check("down_wrap", 32'(wrap), 1);

        // Zero-width window: output parks at lo, never wraps.
        base_freq   = 20'd5000;
        sweep_range = 17'd0;
        sweep_speed = 13'd1000;
        sweep_mode  = 2'b01;
        step(2);
        check("flat_start", 32'(freq_cur), 5000);
        wraps = 0;
        upds  = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            wraps += int'(wrap);
            upds  += int'(freq_upd);
        end
        check("flat_wraps", 32'(wraps), 0);
        check("flat_upds", 32'(upds), 0);
        check("flat_freq", 32'(freq_cur), 5000);

        // Mode to 00 mid-sweep: sweeping drops, output follows base again.
        base_freq  = 20'd777;
        sweep_mode = 2'b00;
        step(1);
        check("off_sweeping", 32'(sweeping), 0);
        check("off_dir", 32'(dir_down), 0);
        step(1);
        check("off_freq", 32'(freq_cur), 777);

        // Async reset mid-sweep clears outputs without waiting for a clock.
        base_freq   = 20'd1000;
        sweep_range = 17'd3000;
        sweep_speed = 13'd1000;
        sweep_mode  = 2'b01;
        step(2);
        wait_upd(n); check("pre_rst_f", 32'(freq_cur), 2000);
        step(3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_freq", 32'(freq_cur), 0);
        check("arst_sweeping", 32'(sweeping), 0);
        check("arst_upd", 32'(freq_upd), 0);
        sweep_mode = 2'b00;
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_idle_freq", 32'(freq_cur), 1000);
        check("post_rst_sweeping", 32'(sweeping), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
